sqrt_pipe_hs: RTL and testbench
===============================

Name: sqrt_pipe_hs

Overview:
- Fully pipelined integer square root with valid/ready handshake on both sides.
- Generalised in operand width; carries a user tag alongside each sample.
- Computes one root bit per stage and reports root and remainder.
- Sits in the object/feature path, e.g. magnitude from squared gradient sums, feeding downstream blocks that may apply backpressure.

Parameters:
- DATA_W, 22, radicand width; must be even and >= 4.
- Q_W, DATA_W/2, root width (derived; not to be overridden).
- R_W, DATA_W/2+1, remainder width (derived).
- TAG_W, 8, width of the sideband tag carried with each sample.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  input sample valid.
- s_ready  out  1  block can accept a sample this cycle.
- s_data  in  DATA_W  unsigned radicand D.
- s_tag  in  TAG_W  user tag, returned unchanged with the result.
- m_valid  out  1  result valid.
- m_ready  in  1  downstream accepts the result.
- m_root  out  Q_W  root, floor(sqrt(D)) by default.
- m_rem  out  R_W  remainder D - floor(sqrt(D))^2.
- m_tag  out  TAG_W  tag of the sample.
- busy  out  1  any pipeline stage holds a valid sample.

Behaviour:
- Pipeline structure:
  - Q_W register stages; stage k (k = 1..Q_W) resolves root bit Q_W-k.
  - Each stage holds: valid bit, partial root q, partial remainder r (R_W+1 bits), unconsumed radicand bits, and the tag.
- Stage arithmetic (restoring, unsigned):
  - r' = (r << 2) | next two radicand MSBs.
  - t = (q << 2) | 1.
  - If r' >= t: r = r' - t, q = (q << 1) | 1. Otherwise r = r', q = q << 1.
  - Stage 1 starts from q = 0, r = 0.
- Global advance: adv = m_ready | ~m_valid. s_ready = adv, combinational.
- When adv = 1:
  - Every stage loads from its predecessor.
  - Stage 1 loads from the input port, with valid = s_valid & s_ready.
- When adv = 0: all stages hold, including m_* outputs.
- Latency:
  - A sample accepted at rising edge N shows m_valid = 1 after edge N+Q_W-1, i.e. Q_W registered stages, with the last stage driving m_*.
  - Throughput is one sample per cycle while m_ready = 1.
- Zeroing rules:
  - A stage loaded with valid = 0 also clears its q, r and tag.
  - m_root, m_rem and m_tag are 0 whenever m_valid = 0.
- Output holding: while m_valid = 1 and m_ready = 0, m_* stay stable until the handshake completes. No sample is lost or reordered.
- busy = OR of all stage valid bits.
- Reset:
  - rst_n low clears every valid, q, r and tag register asynchronously, regardless of in-flight samples.
  - Outputs after reset: m_valid = 0, m_root = 0, m_rem = 0, m_tag = 0, busy = 0, s_ready = 1.
  - In-flight samples are discarded, not flushed.
- Boundaries:
  - D = 0 gives root 0, rem 0.
  - D = 2^DATA_W-1 gives root 2^Q_W-1, rem 2^(Q_W+1)-2, which fits in R_W.
  - Input accepted in the same cycle as an output handshake is legal; the pipeline shifts once.

Optional Feature:
- Macro: SQRT_PIPE_ROUND_EN.
- When defined:
  - m_root = floor root + 1 when final rem > floor root (round to nearest; the exact .5 case cannot occur for integers).
  - The result saturates at 2^Q_W-1.
  - Rounding is combinational on the final stage; latency is unchanged.
  - m_rem stays the floor remainder.
- When undefined: m_root is the floor root and no rounding logic is built.

Test Plan:
- DATA_W=22, m_ready=1, s_data=1000000, tag=0x5A, single pulse -> after 11 cycles m_valid=1 for 1 cycle with root=1000, rem=0, tag=0x5A.
- s_data=0 then s_data=4194303 on consecutive cycles -> consecutive results (0,0) then (2047,4094). With SQRT_PIPE_ROUND_EN the second root is still 2047 (saturated).
- s_data=99 -> root=9, rem=18. With SQRT_PIPE_ROUND_EN root=10, rem=18.
- Stream 20 back-to-back samples D=i*i+i for i=0..19, tags 0..19, while toggling m_ready 0/1 every 3 cycles -> all 20 results in order with root=i, rem=i. s_ready=0 exactly when m_valid=1 and m_ready=0. m_* stable while stalled.
- Reset pulse (rst_n low 2 cycles) with 5 samples in flight -> m_valid=0 and busy=0 immediately; no stale result appears afterwards; next sample D=144 returns root 12 after 11 cycles.

Source files
------------

// File: rtl/sqrt_pipe_hs.sv
// Fully pipelined restoring integer square root, one root bit per stage, valid/ready on both sides.
// Optional round-to-nearest on the final stage when SQRT_PIPE_ROUND_EN is defined.
module sqrt_pipe_hs #(
  parameter  int DATA_W = 22,
  parameter  int TAG_W  = 8,
  localparam int Q_W    = DATA_W / 2,
  localparam int R_W    = DATA_W / 2 + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic [TAG_W-1:0]  s_tag,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [Q_W-1:0]    m_root,
  output logic [R_W-1:0]    m_rem,
  output logic [TAG_W-1:0]  m_tag,
  output logic              busy
);

  localparam int RW1 = R_W + 1;

  logic                adv;

  logic [Q_W-1:0]      v_q, v_d;
  logic [Q_W-1:0]      q_q   [Q_W];
  logic [Q_W-1:0]      q_d   [Q_W];
  logic [RW1-1:0]      r_q   [Q_W];
  logic [RW1-1:0]      r_d   [Q_W];
  logic [DATA_W-1:0]   rad_q [Q_W];
  logic [DATA_W-1:0]   rad_d [Q_W];
  logic [TAG_W-1:0]    tag_q [Q_W];
  logic [TAG_W-1:0]    tag_d [Q_W];

  // Stage inputs: stage 0 sees the input port, stage s sees register s-1.
  logic [Q_W-1:0]      pv;
  logic [Q_W-1:0]      pq    [Q_W];
  logic [RW1-1:0]      pr    [Q_W];
  logic [DATA_W-1:0]   prad  [Q_W];
  logic [TAG_W-1:0]    ptag  [Q_W];

  logic [RW1-1:0]      rp_c  [Q_W];
  logic [RW1-1:0]      t_c   [Q_W];

  assign adv     = m_ready | ~v_q[Q_W-1];
  assign s_ready = adv;

  always_comb begin
    pv       = '0;
    pv[0]    = s_valid & adv;
    pq[0]    = '0;
    pr[0]    = '0;
    prad[0]  = s_data;
    ptag[0]  = s_tag;
    for (int unsigned s = 1; s < Q_W; s++) begin
      pv[s]   = v_q[s-1];
      pq[s]   = q_q[s-1];
      pr[s]   = r_q[s-1];
      prad[s] = rad_q[s-1];
      ptag[s] = tag_q[s-1];
    end
  end

  // The shifted-out top bits of r are always zero: a stored remainder never exceeds 2q.
  always_comb begin
    for (int unsigned s = 0; s < Q_W; s++) begin
      rp_c[s]  = {pr[s][RW1-3:0], prad[s][DATA_W-1:DATA_W-2]};
      t_c[s]   = {pq[s], 2'b01};
      v_d[s]   = pv[s];
      q_d[s]   = '0;
      r_d[s]   = '0;
      rad_d[s] = '0;
      tag_d[s] = '0;
      if (pv[s]) begin
        rad_d[s] = {prad[s][DATA_W-3:0], 2'b00};
        tag_d[s] = ptag[s];
        if (rp_c[s] >= t_c[s]) begin
          r_d[s] = rp_c[s] - t_c[s];
          q_d[s] = {pq[s][Q_W-2:0], 1'b1};
        end else begin
          r_d[s] = rp_c[s];
          q_d[s] = {pq[s][Q_W-2:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int unsigned s = 0; s < Q_W; s++) begin
        q_q[s]   <= '0;
        r_q[s]   <= '0;
        rad_q[s] <= '0;
        tag_q[s] <= '0;
      end
    end else if (adv) begin
      v_q   <= v_d;
      q_q   <= q_d;
      r_q   <= r_d;
      rad_q <= rad_d;
      tag_q <= tag_d;
    end
  end

  assign m_valid = v_q[Q_W-1];
  assign m_rem   = r_q[Q_W-1][R_W-1:0];
  assign m_tag   = tag_q[Q_W-1];
  assign busy    = |v_q;

`ifdef SQRT_PIPE_ROUND_EN
  // rem > root means D is past (root + 0.5)^2; all-ones root saturates instead of wrapping.
  assign m_root = (m_rem > {1'b0, q_q[Q_W-1]} && !(&q_q[Q_W-1])) ? q_q[Q_W-1] + 1'b1
                                                                 : q_q[Q_W-1];
`else
  assign m_root = q_q[Q_W-1];
`endif

  // Final-stage radicand and remainder MSB carry no information past the last stage.
  logic unused_tail;
  assign unused_tail = ^{rad_q[Q_W-1], r_q[Q_W-1][RW1-1]};

endmodule

// File: tb/tb_sqrt_pipe_hs.sv
// Self-checking bench for sqrt_pipe_hs: directed boundary cases plus randomized traffic
// against a plain-arithmetic square-root model and an in-order scoreboard.
module tb_sqrt_pipe_hs;

  localparam int DATA_W = 22;
  localparam int TAG_W  = 8;
  localparam int Q_W    = DATA_W / 2;
  localparam int R_W    = Q_W + 1;
`ifdef SQRT_PIPE_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic [TAG_W-1:0]  s_tag;
  logic              m_valid;
  logic              m_ready;
  logic [Q_W-1:0]    m_root;
  logic [R_W-1:0]    m_rem;
  logic [TAG_W-1:0]  m_tag;
  logic              busy;

  always #5 clk = ~clk;

  sqrt_pipe_hs #(.DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_tag   (s_tag),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_root  (m_root),
    .m_rem   (m_rem),
    .m_tag   (m_tag),
    .busy    (busy)
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_out = 0;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    longint root;
    longint rem;
    longint tag;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;

  function automatic longint isqrt(input longint d);
    longint r = 0;
    for (int b = Q_W - 1; b >= 0; b--) begin
      longint c = r + (longint'(1) << b);
      if (c * c <= d) r = c;
    end
    return r;
  endfunction

  function automatic exp_t model(input longint d, input longint tag);
    exp_t   e;
    longint f = isqrt(d);
    e.rem  = d - f * f;
    e.root = f;
    if (ROUND && e.rem > f && f < (longint'(1) << Q_W) - 1) e.root = f + 1;
    e.tag  = tag;
    return e;
  endfunction

  // Monitor: scoreboard push on input handshake, pop/compare on output handshake,
  // plus per-cycle handshake, zeroing and stall-stability rules.
  logic        stall_prev = 1'b0;
  logic [31:0] out_prev   = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (s_valid && s_ready) sb.push_back(model(longint'(s_data), longint'(s_tag)));
      check_eq("s_ready", longint'(s_ready), longint'(!(m_valid && !m_ready)));
      if (!m_valid) check_eq("idle_zero", longint'({m_root, m_rem, m_tag}), 0);
      if (stall_prev) check_eq("hold", longint'({m_valid, m_root, m_rem, m_tag}), longint'(out_prev));
      if (m_valid && m_ready) begin
        n_out++;
        if (sb.size() == 0) begin
          check_eq("unexpected_out", 1, 0);
        end else begin
          e_mon = sb.pop_front();
          check_eq("root", longint'(m_root), e_mon.root);
          check_eq("rem",  longint'(m_rem),  e_mon.rem);
          check_eq("tag",  longint'(m_tag),  e_mon.tag);
        end
      end
      stall_prev = m_valid && !m_ready;
      out_prev   = {m_valid, m_root, m_rem, m_tag};
    end
  end

  // Present a sample and hold it until accepted; returns at accepting edge + #1 with s_valid still high.
  task automatic send(input longint d, input longint tag);
    bit ok = 1'b0;
    s_valid = 1'b1;
    s_data  = DATA_W'(d);
    s_tag   = TAG_W'(tag);
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (s_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!ok) check_eq("send_timeout", 0, 1);
  endtask

  task automatic wait_valid(output int k);
    k = 0;
    while (!m_valid && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  task automatic run_one(input longint d, input longint tag, input longint er, input longint em);
    int k;
    m_ready = 1'b1;
    send(d, tag);
    s_valid = 1'b0;
    wait_valid(k);
    check_eq("latency", k, Q_W - 1);
    check_eq("d_root", longint'(m_root), er);
    check_eq("d_rem",  longint'(m_rem),  em);
    check_eq("d_tag",  longint'(m_tag),  tag);
    @(posedge clk);
    #1;
    check_eq("one_shot", longint'(m_valid), 0);
  endtask

  task automatic drain();
    m_ready = 1'b1;
    for (int k = 0; k < 100 && sb.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    check_eq("drain", sb.size(), 0);
  endtask

  bit stream_done;
  bit rnd_done;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int     k;
    int     base;
    int     seen;
    longint d;
    longint maxd = (longint'(1) << DATA_W) - 1;

    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_tag   = '0;
    m_ready = 1'b0;
    #12;
    check_eq("rst_m_valid", longint'(m_valid), 0);
    check_eq("rst_busy",    longint'(busy), 0);
    check_eq("rst_s_ready", longint'(s_ready), 1);
    check_eq("rst_outs",    longint'({m_root, m_rem, m_tag}), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_one(1000000, 'h5A, 1000, 0);
    run_one(99, 7, ROUND ? 10 : 9, 18);

    // D = 0 then max back-to-back: consecutive results
    m_ready = 1'b1;
    send(0, 1);
    send(maxd, 2);
    s_valid = 1'b0;
    wait_valid(k);
    check_eq("zero_root", longint'(m_root), 0);
    check_eq("zero_rem",  longint'(m_rem), 0);
    @(posedge clk);
    #1;
    check_eq("max_valid", longint'(m_valid), 1);
    check_eq("max_root",  longint'(m_root), 2047);
    check_eq("max_rem",   longint'(m_rem), 4094);
    check_eq("max_tag",   longint'(m_tag), 2);
    drain();

    // 20 samples D = i*i+i under periodic backpressure
    base        = n_out;
    stream_done = 1'b0;
    m_ready     = 1'b1;
    fork
      begin
        for (int i = 0; i < 20; i++) send(longint'(i) * i + i, i);
        s_valid     = 1'b0;
        stream_done = 1'b1;
      end
      begin
        int c = 0;
        while (!stream_done) begin
          @(posedge clk);
          #1;
          c++;
          if (c % 3 == 0) m_ready = ~m_ready;
        end
      end
    join
    drain();
    check_eq("stream_count", n_out - base, 20);

    // randomized traffic with random gaps and random backpressure
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          s_valid = 1'b0;
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          case ($urandom_range(0, 7))
            0:       d = 0;
            1:       d = maxd;
            2: begin
              d = longint'($urandom_range(0, (1 << Q_W) - 1));
              d = d * d;
            end
            default: d = longint'($urandom) & maxd;
          endcase
          send(d, longint'($urandom_range(0, 255)));
        end
        s_valid  = 1'b0;
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          m_ready = ($urandom_range(0, 9) < 6);
        end
      end
    join
    drain();

    // asynchronous reset with samples in flight
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) send(1000 + i, 100 + i);
    s_valid = 1'b0;
    check_eq("busy_pre", longint'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_m_valid", longint'(m_valid), 0);
    check_eq("arst_busy",    longint'(busy), 0);
    check_eq("arst_s_ready", longint'(s_ready), 1);
    check_eq("arst_outs",    longint'({m_root, m_rem, m_tag}), 0);
    sb.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (m_valid) seen++;
    end
    check_eq("no_stale", seen, 0);
    run_one(144, 'h33, 12, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
